// File: rtl/bcd_ascii_streamer.sv
// Streams a snapshotted 4-digit packed-BCD value as four ASCII characters, MSD first.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_ascii_streamer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_load,
  output logic        busy,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        done
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned VALUE_W = 4 * DIGIT_W;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_n;
  logic [1:0]           idx, idx_n;
  logic [VALUE_W-1:0]   snap, snap_n;
  logic                 busy_n, valid_n, done_n;
  logic [CHAR_W-1:0]    char_n;
  logic                 handshake;

  function automatic logic [DIGIT_W-1:0] nib_at(input logic [VALUE_W-1:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  // Digit is blanked when it and every more-significant digit are zero; the last digit never is.
  function automatic logic lead_zero(input logic [VALUE_W-1:0] v, input logic [1:0] i);
    logic z;
    z = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if ((2'(k) <= i) && (nib_at(v, 2'(k)) != 4'h0)) z = 1'b0;
    end
    return BLANK_EN && (i != 2'd3) && z;
  endfunction

  function automatic logic [CHAR_W-1:0] char_of(input logic [VALUE_W-1:0] v, input logic [1:0] i);
    logic [DIGIT_W-1:0] d;
    d = nib_at(v, i);
    if (lead_zero(v, i))   return BLANK_CHAR;
    else if (d <= 4'd9)    return 8'h30 + CHAR_W'(d);
    else                   return BAD_CHAR;
  endfunction

  assign handshake = char_valid && char_ready;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      snap       <= 16'h0000;
      busy       <= 1'b0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      snap       <= snap_n;
      busy       <= busy_n;
      char_out   <= char_n;
      char_valid <= valid_n;
      done       <= done_n;
    end
  end

  // Next-state: snapshot on accepted load, advance digit on each handshake.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    snap_n  = snap;
    case (state)
      IDLE: begin
        if (bcd_load) begin
          state_n = SEND;
          idx_n   = 2'd0;
          snap_n  = bcd_in;
        end
      end
      SEND: begin
        if (handshake) begin
          if (idx == 2'd3) begin
            state_n = IDLE;
            idx_n   = 2'd0;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output next values; the first character is decoded straight from bcd_in to hit 1-cycle latency.
  always_comb begin
    busy_n  = busy;
    char_n  = char_out;
    valid_n = char_valid;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bcd_load) begin
          busy_n  = 1'b1;
          valid_n = 1'b1;
          char_n  = char_of(bcd_in, 2'd0);
        end
      end
      SEND: begin
        if (handshake) begin
          if (idx == 2'd3) begin
            busy_n  = 1'b0;
            valid_n = 1'b0;
            char_n  = 8'h00;
            done_n  = 1'b1;
          end else begin
            char_n = char_of(snap, idx + 2'd1);
          end
        end
      end
      default: begin
        busy_n  = 1'b0;
        valid_n = 1'b0;
        char_n  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Directed bench for bcd_ascii_streamer; expectations follow LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_ascii_streamer;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        bcd_load;
  logic        busy;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        done;

  int total;
  int bad;

  bcd_ascii_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .bcd_load   (bcd_load),
    .busy       (busy),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads v, then collects four characters; stall = ready-low cycles per character.
  // mid=1 pulses a load of 16'h2222 while the string is in flight. Returns in the done cycle.
  task automatic capture(input logic [15:0] v, input int stall, input bit mid,
                         output logic [31:0] got, output int done_cyc,
                         output int unstable, output int busy_bad);
    int n;
    int sc;
    logic [7:0] first;
    got = 32'h0; done_cyc = -1; unstable = 0; busy_bad = 0;
    n = 0; sc = 0; first = 8'h00;
    bcd_in = v;
    bcd_load = 1'b1;
    char_ready = 1'b0;
    step();
    bcd_load = 1'b0;
    bcd_in = 16'hFFFF;
    for (int c = 1; c < 200; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      bcd_load = 1'b0;
      if (mid && c == 2) begin
        bcd_load = 1'b1;
        bcd_in = 16'h2222;
      end
      if (char_valid) begin
        if (!busy) busy_bad++;
        if (sc == 0) first = char_out;
        else if (char_out !== first) unstable++;
        if (sc < stall) begin
          char_ready = 1'b0;
          sc++;
        end else begin
          char_ready = 1'b1;
          if (n < 4) got = {got[23:0], char_out};
          n++;
          sc = 0;
        end
      end else begin
        char_ready = 1'b0;
      end
      step();
    end
    bcd_load = 1'b0;
    char_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bcd_load = 1'b0; bcd_in = 16'h0; char_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    total++;
    if ({busy, char_valid, done, char_out} !== 11'h000) begin
      $display("FAIL reset_outputs got busy=%b valid=%b done=%b char=%h want all 0", busy, char_valid, done, char_out);
      bad++;
    end
  endtask

  task automatic test_basic();
    logic [31:0] got; int dc, un, bb;
    bcd_in = 16'h1234; bcd_load = 1'b1; char_ready = 1'b1;
    step();
    bcd_load = 1'b0;
    total++;
    if (!(busy === 1'b1 && char_valid === 1'b1 && char_out === 8'h31)) begin
      $display("FAIL basic_latency got busy=%b valid=%b char=%h want 1 1 31", busy, char_valid, char_out);
      bad++;
    end
    for (int k = 0; k < 3; k++) step();
    total++;
    if (char_out !== 8'h34 || char_valid !== 1'b1) begin
      $display("FAIL basic_fourth got char=%h valid=%b want 34 1", char_out, char_valid);
      bad++;
    end
    step();
    total++;
    if (!(done === 1'b1 && busy === 1'b0 && char_valid === 1'b0)) begin
      $display("FAIL basic_done got done=%b busy=%b valid=%b want 1 0 0", done, busy, char_valid);
      bad++;
    end
    char_ready = 1'b0;
    step();
    total++;
    if (done !== 1'b0) begin
      $display("FAIL basic_done_pulse got done=%b want 0", done);
      bad++;
    end
    capture(16'h1234, 0, 1'b0, got, dc, un, bb);
    total++;
    if (got !== 32'h31323334 || dc != 5 || bb != 0) begin
      $display("FAIL basic_capture got %h done_cyc=%0d busy_bad=%0d want 31323334 5 0", got, dc, bb);
      bad++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] got, want; int dc, un, bb;
`ifdef LEADING_ZERO_BLANK_EN
    want = 32'h20393035;
`else
    want = 32'h30393035;
`endif
    step();
    capture(16'h0905, 3, 1'b0, got, dc, un, bb);
    total++;
    if (got !== want) begin
      $display("FAIL stall_chars got %h want %h", got, want);
      bad++;
    end
    total++;
    if (un != 0 || dc != 17) begin
      $display("FAIL stall_hold got unstable=%0d done_cyc=%0d want 0 17", un, dc);
      bad++;
    end
  endtask

  task automatic test_patterns();
    logic [31:0] got; int dc, un, bb;
    logic [15:0] vals [3];
    logic [31:0] want [3];
    vals[0] = 16'h0000; vals[1] = 16'h9A99; vals[2] = 16'h0A00;
`ifdef LEADING_ZERO_BLANK_EN
    want[0] = 32'h20202030; want[1] = 32'h393F3939; want[2] = 32'h203F3030;
`else
    want[0] = 32'h30303030; want[1] = 32'h393F3939; want[2] = 32'h303F3030;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      capture(vals[i], 0, 1'b0, got, dc, un, bb);
      total++;
      if (got !== want[i] || dc != 5) begin
        $display("FAIL pattern_%h got %h done_cyc=%0d want %h 5", vals[i], got, dc, want[i]);
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got; int dc, un, bb;
    step();
    capture(16'h1111, 0, 1'b1, got, dc, un, bb);
    total++;
    if (got !== 32'h31313131 || dc != 5) begin
      $display("FAIL ignore_busy_load got %h done_cyc=%0d want 31313131 5", got, dc);
      bad++;
    end
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL done_cycle_busy got %b want 0", busy);
      bad++;
    end
    capture(16'h2222, 0, 1'b0, got, dc, un, bb);
    total++;
    if (got !== 32'h32323232 || dc != 5) begin
      $display("FAIL load_in_done_cycle got %h done_cyc=%0d want 32323232 5", got, dc);
      bad++;
    end
    step();
    total++;
    if (char_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL idle_after got valid=%b busy=%b want 0 0", char_valid, busy);
      bad++;
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] got; int dc, un, bb; int seen_done;
    bcd_in = 16'h1234; bcd_load = 1'b1; char_ready = 1'b1;
    step();
    bcd_load = 1'b0;
    step();
    total++;
    if (char_out !== 8'h32) begin
      $display("FAIL mid_reset_second got %h want 32", char_out);
      bad++;
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({busy, char_valid, done, char_out} !== 11'h000) begin
      $display("FAIL mid_reset_outputs got busy=%b valid=%b done=%b char=%h want all 0", busy, char_valid, done, char_out);
      bad++;
    end
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || char_valid) seen_done++;
      step();
    end
    total++;
    if (seen_done != 0) begin
      $display("FAIL mid_reset_quiet got %0d active cycles want 0", seen_done);
      bad++;
    end
    capture(16'h5678, 0, 1'b0, got, dc, un, bb);
    total++;
    if (got !== 32'h35363738 || dc != 5) begin
      $display("FAIL after_reset got %h done_cyc=%0d want 35363738 5", got, dc);
      bad++;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1; bcd_load = 1'b0; bcd_in = 16'h0; char_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_patterns();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_ascii_streamer.md
# bcd_ascii_streamer

Converts a captured 4-digit packed-BCD value, such as the counter value from the BCD increment stage, into four ASCII characters. It emits them one per handshake, most-significant digit first, towards the 12864 LCD character-write path. Sits directly downstream of the 4-digit BCD incrementer and upstream of the LCD command/data sequencer. The value is snapshotted at request time, so the counter may keep changing while a string is being sent.

## Interface
- `BLANK_CHAR`, default 8'h20: character substituted for suppressed leading zeros (only used with `LEADING_ZERO_BLANK_EN`).
- `BAD_CHAR`, default 8'h3F: character emitted for a non-decimal nibble (4'hA–4'hF).
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bcd_in`  in  16  packed BCD; [15:12] most significant digit, [3:0] least significant.
- `bcd_load`  in  1  request to snapshot `bcd_in` and start streaming; honoured only while `busy`=0.
- `busy`  out  1  high from the cycle after an accepted load until the last character is accepted.
- `char_out`  out  8  ASCII character; valid while `char_valid`=1.
- `char_valid`  out  1  character available.
- `char_ready`  in  1  consumer accepts `char_out` when `char_valid`&&`char_ready`.
- `done`  out  1  one-cycle pulse after the 4th character is accepted.

## Operation
- States: IDLE, SEND. Digit index `idx` is 2 bits: 0 = [15:12] … 3 = [3:0].
- IDLE with `bcd_load`=1:
  - snapshot `bcd_in` into an internal register and set `idx`=0;
  - go to SEND.
- IDLE with `bcd_load`=0: no state change; outputs hold their idle values.
- SEND:
  - `char_valid`=1; `char_out` = character for digit `idx`.
  - Digit 0–9 maps to 8'h30 + digit; 4'hA–4'hF maps to `BAD_CHAR`.
- Handshake:
  - `char_out` and `char_valid` stay stable until `char_valid`&&`char_ready`.
  - On a handshake with `idx`<3: `idx`+1 and the next character is presented the following cycle.
  - On a handshake with `idx`=3: go to IDLE; `done`=1 for the next cycle only.
- Requests are not queued:
  - `bcd_load` while busy is ignored, and `bcd_in` changes while busy have no effect.
  - `bcd_load` in the cycle `done` is high is accepted, because `busy` is already 0.
- Reset (mid-string included): IDLE, `idx`=0, snapshot=16'h0000, `busy`=0, `char_valid`=0, `char_out`=8'h00, `done`=0. A partial string is abandoned and no `done` is issued.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Load accepted at edge n: `busy`=1 and `char_valid`=1 from cycle n+1 (1-cycle latency).
- With `char_ready` tied high:
  - one character per cycle;
  - 4 cycles of `char_valid`; `done` in cycle n+5; next load accepted in cycle n+5.
- `char_ready` low holds the current character indefinitely; no timeout.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - digits at `idx` 0–2 that equal 0 and precede the first nonzero digit are emitted as `BLANK_CHAR`;
  - digit `idx`=3 is always emitted as a numeral;
  - a non-decimal nibble counts as nonzero;
  - blanking is decided from the snapshot, so the character count stays 4.
- Not defined: every digit is emitted literally; `BLANK_CHAR` is unused.

## Test plan
- Reset, then load 16'h1234 with `char_ready`=1 → chars 31,32,33,34 in cycles n+1..n+4; `done` in n+5; `busy` low in n+5.
- Load 16'h0905 with `char_ready` low for 3 cycles at each character → each char held stable; sequence 30,39,30,35 (blanking off), or 20,39,30,35 with `LEADING_ZERO_BLANK_EN`.
- Load 16'h0000 → 30,30,30,30 (blanking off), or 20,20,20,30 (blanking on).
- Load 16'h9A99 → 39,3F,39,39; with blanking on and 16'h0A00 → 20,3F,30,30.
- Load 16'h1111, then pulse `bcd_load` with 16'h2222 mid-string → 31×4 only; a second load asserted in the `done` cycle → 32×4 starts the next cycle.
- Assert `rst` after the 2nd character → next cycle all outputs at reset values and no `done`; a subsequent load of 16'h5678 → 35,36,37,38.
